// File: rtl/dw_fifo_s1_sf.sv
// Single-clock FIFO with static flag thresholds and active-low push/pop.
// Used as the data-return queue of the VRF read stage: read data is pushed
// by the delayed read-fire strobe and drained by the consumer's handshake.
// data_out is a combinational read of the head entry (no fall-through), and
// every flag is decoded from the registered word count.
module dw_fifo_s1_sf #(
    parameter int width    = 32,
    parameter int depth    = 4,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int ptrWidth = (depth > 1) ? $clog2(depth) : 1;
    localparam int cntWidth = $clog2(depth + 1);

    localparam logic [ptrWidth-1:0] lastPtr    = ptrWidth'(depth - 1);
    localparam logic [cntWidth-1:0] depthCount = cntWidth'(depth);
    localparam logic [cntWidth-1:0] aeCount    = cntWidth'(ae_level);
    localparam logic [cntWidth-1:0] hfCount    = cntWidth'((depth + 1) / 2);
    localparam logic [cntWidth-1:0] afCount    = cntWidth'(depth - af_level);

    logic [width-1:0]    storage [depth];
    logic [ptrWidth-1:0] readPtr;
    logic [ptrWidth-1:0] writePtr;
    logic [cntWidth-1:0] wordCount;
    logic                errorReg;

    logic pushReq;
    logic popReq;
    logic isEmpty;
    logic isFull;
    logic doPush;
    logic doPop;
    logic overflow;
    logic underflow;
    logic errorNext;

    // Decode requests; a push into a full queue is legal only alongside a pop,
    // which frees the head slot on the same edge.
    always_comb begin
        pushReq   = ~push_req_n;
        popReq    = ~pop_req_n;
        isEmpty   = (wordCount == '0);
        isFull    = (wordCount == depthCount);
        doPush    = pushReq & (~isFull | popReq);
        doPop     = popReq & ~isEmpty;
        overflow  = pushReq & ~popReq & isFull;
        underflow = popReq & isEmpty;
    end

    // Write the incoming word at the tail; storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && doPush) begin
            storage[writePtr] <= data_in;
        end
    end

    // Pointer and count state; pointers wrap explicitly so depth may be any value.
    always_ff @(posedge clock) begin
        if (reset) begin
            readPtr   <= '0;
            writePtr  <= '0;
            wordCount <= '0;
        end else begin
            if (doPush) begin
                writePtr <= (writePtr == lastPtr) ? '0 : writePtr + 1'b1;
            end
            if (doPop) begin
                readPtr <= (readPtr == lastPtr) ? '0 : readPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   wordCount <= wordCount + 1'b1;
                2'b01:   wordCount <= wordCount - 1'b1;
                default: wordCount <= wordCount;
            endcase
        end
    end

    // Next error value: per-cycle, sticky, or sticky with diag_n clear.
    always_comb begin
        errorNext = errorReg;
        case (err_mode)
            0: begin
                if (overflow | underflow) begin
                    errorNext = 1'b1;
                end else if (!diag_n) begin
                    errorNext = 1'b0;
                end
            end
            1:       errorNext = errorReg | overflow | underflow;
            default: errorNext = overflow | underflow;
        endcase
    end

    // Error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            errorReg <= 1'b0;
        end else begin
            errorReg <= errorNext;
        end
    end

    // Status flags and head-of-queue data from registered state.
    always_comb begin
        empty        = isEmpty;
        full         = isFull;
        almost_empty = (wordCount <= aeCount);
        half_full    = (wordCount >= hfCount);
        almost_full  = (wordCount >= afCount);
        error        = errorReg;
        data_out     = storage[readPtr];
    end

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
// Directed bench for dw_fifo_s1_sf (depth 4, width 32). Two instances share
// all inputs: one with per-cycle error (err_mode 2), one with diag_n-clearable
// sticky error (err_mode 0). A vector table covers fill/drain, overflow,
// underflow and simultaneous push/pop; hand sequences cover wrap-around and
// mid-stream reset.
module tb_dw_fifo_s1_sf;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         push_req_n;
    logic         pop_req_n;
    logic         diag_n;
    logic [W-1:0] data_in;

    logic         empty, almost_empty, half_full, almost_full, full, error;
    logic [W-1:0] data_out;
    logic         empty0, almostEmpty0, halfFull0, almostFull0, full0, error0;
    logic [W-1:0] dataOut0;

    dw_fifo_s1_sf #(.width(W), .depth(4), .ae_level(1), .af_level(1), .err_mode(2)) u_dut (
        .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .diag_n(diag_n), .data_in(data_in), .empty(empty), .almost_empty(almost_empty),
        .half_full(half_full), .almost_full(almost_full), .full(full), .error(error),
        .data_out(data_out)
    );

    dw_fifo_s1_sf #(.width(W), .depth(4), .ae_level(1), .af_level(1), .err_mode(0)) u_dut0 (
        .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .diag_n(diag_n), .data_in(data_in), .empty(empty0), .almost_empty(almostEmpty0),
        .half_full(halfFull0), .almost_full(almostFull0), .full(full0), .error(error0),
        .data_out(dataOut0)
    );

    always #5 clock = ~clock;

    // Flag encodings {empty, almost_empty, half_full, almost_full, full, error}
    localparam logic [5:0] C0 = 6'b110000;
    localparam logic [5:0] C1 = 6'b010000;
    localparam logic [5:0] C2 = 6'b001000;
    localparam logic [5:0] C3 = 6'b001100;
    localparam logic [5:0] C4 = 6'b001110;
    localparam logic [5:0] ER = 6'b000001;

    typedef struct {
        logic         rst;
        logic         pushN;
        logic         popN;
        logic         diagN;
        logic [W-1:0] din;
        logic [5:0]   expFlags;
        logic         expErr0;
        logic         chkData;
        logic [W-1:0] expData;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(logic r, logic pn, logic qn, logic dn, logic [W-1:0] d,
                                logic [5:0] f, logic e0, logic cd, logic [W-1:0] ed);
        vec_t v;
        v.rst = r; v.pushN = pn; v.popN = qn; v.diagN = dn; v.din = d;
        v.expFlags = f; v.expErr0 = e0; v.chkData = cd; v.expData = ed;
        return v;
    endfunction

    // Apply one cycle of inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic r, input logic pn, input logic qn, input logic dn,
                         input logic [W-1:0] d);
        @(negedge clock);
        reset = r; push_req_n = pn; pop_req_n = qn; diag_n = dn; data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkFlags(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {empty, almost_empty, half_full, almost_full, full, error};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s flags got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkErr0(input string name, input logic exp);
        vectors++;
        if (error0 !== exp) begin
            miscompares++;
            $display("FAIL %s err_mode0 error got %b want %b", name, error0, exp);
        end
    endtask

    task automatic checkData(input string name, input logic [W-1:0] exp);
        vectors++;
        if (data_out !== exp) begin
            miscompares++;
            $display("FAIL %s data_out got %h want %h", name, data_out, exp);
        end
    endtask

    initial begin
        reset = 1'b1; push_req_n = 1'b1; pop_req_n = 1'b1; diag_n = 1'b1; data_in = '0;

        //              rst pn  qn  dn  din    flags     e0  cd  data
        // Reset, idle, fill to full
        vecs.push_back(mk(1, 1, 1, 1, 32'h0,  C0,      0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h0,  C0,      0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h11, C1,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h22, C2,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h33, C3,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h44, C4,      0,  1, 32'h11));
        // Overflow: one-cycle error in mode 2, sticky until diag_n in mode 0
        vecs.push_back(mk(0, 0, 1, 1, 32'h55, C4 | ER, 1,  1, 32'h11));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,  C4,      0,  1, 32'h11));
        // Drain: 0x55 must not appear
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C3,      0,  1, 32'h22));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C2,      0,  1, 32'h33));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C1,      0,  1, 32'h44));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C0,      0,  0, 32'h0));
        // Refill, then push+pop while full
        vecs.push_back(mk(0, 0, 1, 1, 32'h11, C1,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h22, C2,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h33, C3,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 1, 1, 32'h44, C4,      0,  1, 32'h11));
        vecs.push_back(mk(0, 0, 0, 1, 32'h66, C4,      0,  1, 32'h22));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C3,      0,  1, 32'h33));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C2,      0,  1, 32'h44));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C1,      0,  1, 32'h66));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C0,      0,  0, 32'h0));
        // Underflow while empty; then push+pop on empty
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C0 | ER, 1,  0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h0,  C0,      1,  0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'hAA, C1 | ER, 1,  1, 32'hAA));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,  C1,      0,  1, 32'hAA));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0,  C0,      0,  0, 32'h0));

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].pushN, vecs[i].popN, vecs[i].diagN, vecs[i].din);
            $display("%s rst=%b push_n=%b pop_n=%b diag_n=%b din=%h -> flags=%b err0=%b dout=%h",
                     nm, vecs[i].rst, vecs[i].pushN, vecs[i].popN, vecs[i].diagN, vecs[i].din,
                     {empty, almost_empty, half_full, almost_full, full, error}, error0, data_out);
            checkFlags(nm, vecs[i].expFlags);
            checkErr0(nm, vecs[i].expErr0);
            if (vecs[i].chkData) checkData(nm, vecs[i].expData);
        end

        // Wrap-around: hold count at 2 across 10 push+pop cycles
        drive(0, 0, 1, 1, 32'h100);
        checkFlags("wrap_fill0", C1);
        drive(0, 0, 1, 1, 32'h101);
        checkFlags("wrap_fill1", C2);
        checkData("wrap_fill1", 32'h100);
        for (int i = 0; i < 10; i++) begin
            string nm;
            logic [W-1:0] d;
            logic [W-1:0] expHead;
            nm = $sformatf("wrap%0d", i);
            d = 32'h102 + W'(i);
            expHead = 32'h101 + W'(i);
            drive(0, 0, 0, 1, d);
            $display("%s push+pop din=%h -> dout=%h flags=%b", nm, d, data_out,
                     {empty, almost_empty, half_full, almost_full, full, error});
            checkFlags(nm, C2);
            checkData(nm, expHead);
        end

        // Mid-stream reset with count 3 and a simultaneous push
        drive(0, 0, 1, 1, 32'h200);
        checkFlags("pre_reset", C3);
        drive(1, 0, 1, 1, 32'h201);
        $display("reset_push -> flags=%b err0=%b", {empty, almost_empty, half_full, almost_full, full, error}, error0);
        checkFlags("reset_push", C0);
        checkErr0("reset_push", 1'b0);
        drive(0, 0, 1, 1, 32'h77);
        $display("post_reset_push din=77 -> flags=%b dout=%h", {empty, almost_empty, half_full, almost_full, full, error}, data_out);
        checkFlags("post_reset_push", C1);
        checkData("post_reset_push", 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
